serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_arith_pkg.sv | 23 ++
 rtl/fs_cell.sv | 31 +++
 rtl/serial_subtractor.sv | 160 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_arith_pkg
// Description : Shared types and constants for the bit-serial arithmetic
//               blocks. It defines the sequencer state encoding and the
//               default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_arith_pkg;

  // Default operand width for the serial arithmetic units.
  localparam int SUB_WIDTH_DEFAULT = 8;

  // Sequencer states. The explicit 2-bit encoding keeps the state register
  // width fixed no matter how tools choose to infer the enum.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

endpackage : serial_arith_pkg
`default_nettype wire

// File: rtl/fs_cell.sv
`default_nettype none
// ============================================================================
// Module      : fs_cell
// Description : 1-bit full subtractor (purely combinational).
//               Computes d = a - b - b_in for a single bit position.
// Ports       : b_out - borrow out of this bit position
//               d     - difference bit
//               a     - minuend bit
//               b     - subtrahend bit
//               b_in  - borrow into this bit position
// Revision    : 1.0 - initial release
// ============================================================================
module fs_cell (
  output logic b_out,
  output logic d,
  input  logic a,
  input  logic b,
  input  logic b_in
);

  logic w_ab_diff;

  assign w_ab_diff = a ^ b;
  assign d         = w_ab_diff ^ b_in;

  // A borrow leaves this bit when b exceeds a outright (a=0, b=1). It also
  // leaves when a and b are equal and a borrow arrives from below.
  assign b_out = (~a & b) | (~w_ab_diff & b_in);

endmodule : fs_cell
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial subtractor. It computes diff = a - b - b_in
//               (mod 2^n) one bit per clock, LSB first. It also reports the
//               final borrow and the two's-complement signed overflow.
//               Latency is fixed. The start is accepted on edge 0, and done
//               pulses for the single cycle that follows edge n.
// Ports       : clk      - clock, all state changes on the rising edge
//               rst_n    - asynchronous active-low reset
//               start    - begin a subtraction (accepted in IDLE/DONE only)
//               a        - minuend, sampled on an accepted start
//               b        - subtrahend, sampled on an accepted start
//               b_in     - borrow-in, sampled on an accepted start
//               busy     - high while bits are being processed
//               done     - one-cycle pulse when diff/b_out/overflow are valid
//               diff     - result a - b - b_in modulo 2^n
//               b_out    - borrow out of the MSB
//               overflow - signed overflow of the result
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int n = SUB_WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] diff,
  output logic         b_out,
  output logic         overflow
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int               CNT_W    = $clog2(n);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(n - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  sub_state_e       state_q,    state_d;
  logic [n-1:0]     a_sr_q,     a_sr_d;
  logic [n-1:0]     b_sr_q,     b_sr_d;
  logic             br_q,       br_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [n-1:0]     diff_q,     diff_d;
  logic             b_out_q,    b_out_d;
  logic             overflow_q, overflow_d;

  // Per-bit arithmetic on the current LSBs of the operand shift registers.
  logic cell_d;
  logic cell_bo;

  fs_cell u_fs_cell (
    .b_out (cell_bo),
    .d     (cell_d),
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .b_in  (br_q)
  );

  // --------------------------------------------------------------------------
  // Next-state / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    br_d       = br_q;
    cnt_d      = cnt_q;
    diff_d     = diff_q;
    b_out_d    = b_out_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Only the operand path is loaded here. The visible result is
          // left alone until RUN starts shifting new bits into it.
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = b_in;
          cnt_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        a_sr_d = {1'b0, a_sr_q[n-1:1]};
        b_sr_d = {1'b0, b_sr_q[n-1:1]};
        br_d   = cell_bo;
        // Each new bit enters at the MSB. After n shifts, bit 0 of the
        // result has moved down to diff[0].
        diff_d = {cell_d, diff_q[n-1:1]};
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // br_q holds the borrow into the MSB here. Signed overflow is
          // that borrow XOR the borrow out of the MSB.
          b_out_d    = cell_bo;
          overflow_d = br_q ^ cell_bo;
          cnt_d      = '0;
          state_d    = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      br_q       <= 1'b0;
      cnt_q      <= '0;
      diff_q     <= '0;
      b_out_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      br_q       <= br_d;
      cnt_q      <= cnt_d;
      diff_q     <= diff_d;
      b_out_q    <= b_out_d;
      overflow_q <= overflow_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Status comes directly from the state register. An asynchronous reset
  // therefore drops busy and done at once.
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign diff     = diff_q;
  assign b_out    = b_out_q;
  assign overflow = overflow_q;

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor (n = 8). It uses
//               directed stimulus and a queue of expected results that is
//               filled when an operation is launched and drained on done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int N = 8;

  typedef struct packed {
    logic [N-1:0] diff;
    logic         b_out;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         b_out;
  logic         overflow;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t last_exp;

  serial_subtractor #(.n(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .b_out    (b_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: unsigned (n+1)-bit difference for diff/borrow, and a true
  // signed-integer range test for overflow.
  function automatic exp_t model(input logic [N-1:0] ta, input logic [N-1:0] tb,
                                 input logic tbin);
    exp_t       e;
    logic [N:0] full;
    int         s;
    full    = {1'b0, ta} - {1'b0, tb} - {{N{1'b0}}, tbin};
    e.diff  = full[N-1:0];
    e.b_out = full[N];
    s       = int'($signed(ta)) - int'($signed(tb)) - int'(tbin);
    e.ovf   = (s > (2 ** (N - 1)) - 1) || (s < -(2 ** (N - 1)));
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     32'(busy),     0);
    check({tag, "_done"},     32'(done),     0);
    check({tag, "_diff"},     32'(diff),     0);
    check({tag, "_b_out"},    32'(b_out),    0);
    check({tag, "_overflow"}, 32'(overflow), 0);
  endtask

  // Call at a falling edge. Start is held for exactly one rising edge.
  task automatic launch(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tbin);
    a     = ta;
    b     = tb;
    b_in  = tbin;
    start = 1'b1;
    sb.push_back(model(ta, tb, tbin));
    @(negedge clk);
    start = 1'b0;
    a     = '0;
    b     = '0;
    b_in  = 1'b0;
  endtask

  // Cycle k is the sample taken k falling edges after the start edge.
  // Busy must be high in cycles 1..N, and done must appear in cycle N+1.
  // The task returns at the falling edge where done was seen.
  task automatic check_op(input string tag, input int first_cyc);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int cyc = first_cyc; cyc <= N + 4; cyc++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        check({tag, "_latency"}, 32'(cyc), 32'(N + 1));
        check({tag, "_busy_in_done"}, 32'(busy), 0);
        check({tag, "_sb_has_entry"}, 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e        = sb.pop_front();
          last_exp = e;
          check({tag, "_diff"},     32'(diff),     32'(e.diff));
          check({tag, "_b_out"},    32'(b_out),    32'(e.b_out));
          check({tag, "_overflow"}, 32'(overflow), 32'(e.ovf));
        end
        break;
      end
      if (cyc <= N) check({tag, "_busy"}, 32'(busy), 1);
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(seen), 1);
  endtask

  // The cycle after done, with start low: done must be gone and results held.
  task automatic check_hold(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_idle_busy"},  32'(busy), 0);
    check({tag, "_hold_diff"},  32'(diff), 32'(last_exp.diff));
    check({tag, "_hold_bout"},  32'(b_out), 32'(last_exp.b_out));
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int seen_cnt;
    seen_cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_cnt++;
    end
    check(tag, 32'(seen_cnt), 0);
  endtask

  initial begin
    start = 1'b0;
    a     = '0;
    b     = '0;
    b_in  = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic subtraction, small positive result.
    launch(8'h05, 8'h03, 1'b0);
    check_op("sub_05_03", 1);
    check_hold("sub_05_03");

    // Negative result, borrow out.
    launch(8'h03, 8'h05, 1'b0);
    check_op("sub_03_05", 1);
    check_hold("sub_03_05");

    // Borrow-in only.
    launch(8'h00, 8'h00, 1'b1);
    check_op("sub_00_00_bin", 1);
    check_hold("sub_00_00_bin");

    // Signed overflow: -128 - 1.
    launch(8'h80, 8'h01, 1'b0);
    check_op("sub_80_01", 1);
    check_hold("sub_80_01");

    // Signed overflow caused purely by the borrow-in: -128 - 0 - 1.
    launch(8'h80, 8'h00, 1'b1);
    check_op("sub_80_00_bin", 1);
    check_hold("sub_80_00_bin");

    // Positive minus negative overflowing: 127 - (-1).
    launch(8'h7F, 8'hFF, 1'b0);
    check_op("sub_7f_ff", 1);
    check_hold("sub_7f_ff");

    // A start in RUN (cycle 3) must be ignored.
    launch(8'h05, 8'h03, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a     = 8'hFF;
    b     = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = '0;
    check_op("ignore_start", 4);
    expect_no_done("ignore_start_no_second_done", N + 3);

    // Reset in the middle of an operation.
    @(negedge clk);
    launch(8'h05, 8'h03, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    sb.delete();
    expect_no_done("mid_reset_no_done", 3);
    rst_n = 1'b1;
    launch(8'h10, 8'h01, 1'b0);
    check_op("after_reset", 1);
    check_hold("after_reset");

    // Back-to-back operation: start held during the DONE cycle.
    launch(8'h05, 8'h03, 1'b0);
    check_op("b2b_first", 1);
    launch(8'h20, 8'h10, 1'b0);
    check_op("b2b_second", 1);
    check_hold("b2b_second");

    check("sb_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_subtractor
`default_nettype wire
